demux_1to4_buffered: RTL and testbench

// - Registered 1-to-4 demultiplexer; the write-side counterpart of the 4-to-1 read mux in the multicycle datapath.
// - Routes one source word to one of four destination lanes selected by Selector.
// - Each lane is a 1-entry holding register with a valid/ready handshake.
// - Sits between a single producer (e.g. ALUOut / MDR) and four independent consumers.

---
 rtl/mips_pkg.sv | 15 +
 rtl/demux_lane.sv | 31 +++
 rtl/demux_1to4_buffered.sv | 88 ++++++++
 tb/tb_demux_1to4_buffered.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath constants: demux lane indices, lane count and a small popcount helper.
package mips_pkg;

  localparam int unsigned DEMUX_LANES = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry holding register with valid/ready handshake; a load wins over a same-cycle drain.
module demux_lane
  import mips_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WORD_LENGTH-1:0] din,
  input  logic                   ready,
  output logic                   valid,
  output logic [WORD_LENGTH-1:0] data
);

  logic drain;
  assign drain = valid & ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to4_buffered.sv
// Registered 1-to-4 demux into four 1-entry lanes; define DEMUX_OCCUPANCY_EN to add a
// registered valid-lane count output.
module demux_1to4_buffered
  import mips_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             Selector,
  input  logic [WORD_LENGTH-1:0] DEMUX_Data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [WORD_LENGTH-1:0] DEMUX_Data0,
  output logic [WORD_LENGTH-1:0] DEMUX_Data1,
  output logic [WORD_LENGTH-1:0] DEMUX_Data2,
  output logic [WORD_LENGTH-1:0] DEMUX_Data3
`ifdef DEMUX_OCCUPANCY_EN
  ,
  output logic [2:0]             Occupancy
`endif
);

  logic                   acc;
  logic [3:0]             load;
  logic [WORD_LENGTH-1:0] lane_data [DEMUX_LANES];

  // Readiness looks only at the selected lane so a stalled lane never blocks the others.
  assign in_ready = ~out_valid[Selector] | out_ready[Selector];
  assign acc      = in_valid & in_ready;

  always_comb begin
    load = '0;
    unique case (Selector)
      LANE0: load[0] = acc;
      LANE1: load[1] = acc;
      LANE2: load[2] = acc;
      LANE3: load[3] = acc;
    endcase
  end

  for (genvar i = 0; i < DEMUX_LANES; i++) begin : g_lane
    demux_lane #(
      .WORD_LENGTH(WORD_LENGTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (load[i]),
      .din  (DEMUX_Data),
      .ready(out_ready[i]),
      .valid(out_valid[i]),
      .data (lane_data[i])
    );
  end

  assign DEMUX_Data0 = lane_data[0];
  assign DEMUX_Data1 = lane_data[1];
  assign DEMUX_Data2 = lane_data[2];
  assign DEMUX_Data3 = lane_data[3];

`ifdef DEMUX_OCCUPANCY_EN
  logic [3:0] valid_next;

  always_comb begin
    valid_next = '0;
    for (int i = 0; i < 4; i++) begin
      valid_next[i] = load[i] | (out_valid[i] & ~out_ready[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Occupancy <= '0;
    end else begin
      Occupancy <= popcount4(valid_next);
    end
  end
`endif

`ifndef SYNTHESIS
  // A stalled offer must be held with the same lane and word until it is taken.
  hold_stable_a: assert property (@(posedge clk) disable iff (!reset)
    (in_valid && !in_ready) |=> (in_valid && $stable(Selector) && $stable(DEMUX_Data)));
`endif

endmodule

// File: tb/tb_demux_1to4_buffered.sv
// Directed plus random bench for demux_1to4_buffered using per-lane expected-word queues.
module tb_demux_1to4_buffered;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Selector = '0;
  logic [31:0] DEMUX_Data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] DEMUX_Data0, DEMUX_Data1, DEMUX_Data2, DEMUX_Data3;
`ifdef DEMUX_OCCUPANCY_EN
  logic [2:0]  Occupancy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: words accepted but not yet consumed, per lane, plus last word loaded per lane.
  logic [31:0] exp_q [4][$];
  logic [31:0] last_word [4];
  int          sent = 0;
  int          recv = 0;
  int          dropped = 0;
  int          recv_lane0 = 0;
  bit          last_acc = 1'b0;

  demux_1to4_buffered #(
    .WORD_LENGTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Selector   (Selector),
    .DEMUX_Data (DEMUX_Data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .DEMUX_Data0(DEMUX_Data0),
    .DEMUX_Data1(DEMUX_Data1),
    .DEMUX_Data2(DEMUX_Data2),
    .DEMUX_Data3(DEMUX_Data3)
`ifdef DEMUX_OCCUPANCY_EN
    ,
    .Occupancy  (Occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_out(input int n);
    case (n)
      0:       lane_out = DEMUX_Data0;
      1:       lane_out = DEMUX_Data1;
      2:       lane_out = DEMUX_Data2;
      default: lane_out = DEMUX_Data3;
    endcase
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int n = 0; n < 4; n++) c += exp_q[n].size();
    return c;
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int n = 0; n < 4; n++) ev[n] = (exp_q[n].size() != 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
    for (int n = 0; n < 4; n++) chk($sformatf("%s_lane%0d", tag, n), 64'(lane_out(n)),
                                     64'(last_word[n]));
`ifdef DEMUX_OCCUPANCY_EN
    chk({tag, "_occupancy"}, 64'(Occupancy), 64'(model_count()));
`endif
  endtask

  // Inputs are already applied; check readiness, consume/offer per model, clock, check state.
  task automatic cycle(input string tag);
    bit exp_ready;
    #1;
    exp_ready = (exp_q[Selector].size() == 0) || out_ready[Selector];
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
    last_acc = in_valid && exp_ready;
    for (int n = 0; n < 4; n++) begin
      if (exp_q[n].size() != 0 && out_ready[n]) begin
        chk($sformatf("%s_drain%0d", tag, n), 64'(lane_out(n)), 64'(exp_q[n][0]));
        void'(exp_q[n].pop_front());
        recv++;
        if (n == 0) recv_lane0++;
      end
    end
    if (last_acc) begin
      exp_q[Selector].push_back(DEMUX_Data);
      last_word[Selector] = DEMUX_Data;
      sent++;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int occ_before;
    int r0;
    for (int n = 0; n < 4; n++) last_word[n] = '0;

    // Power-on reset state.
    #1;
    check_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Per-lane routing.
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      Selector = 2'(i);
      DEMUX_Data = 32'(8'h11 * (i + 1));
      cycle("route");
    end
    in_valid = 1'b0;
    chk("route_all_valid", 64'(out_valid), 64'hF);
    chk("route_lane3", 64'(DEMUX_Data3), 64'h44);
`ifdef DEMUX_OCCUPANCY_EN
    chk("route_occ4", 64'(Occupancy), 64'd4);
`endif

    // Asynchronous reset during an offered transfer.
    in_valid = 1'b1;
    Selector = 2'd2;
    DEMUX_Data = 32'hDEAD_BEEF;
    out_ready = 4'b0100;
    #2;
    reset = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      dropped += exp_q[n].size();
      exp_q[n].delete();
      last_word[n] = '0;
    end
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'b0000;

    // Backpressure on lane 1 leaves other lanes open.
    in_valid = 1'b1;
    Selector = 2'd1;
    DEMUX_Data = 32'hB1;
    cycle("bp_fill");
    Selector = 2'd1;
    DEMUX_Data = 32'hB2;
    #1;
    chk("bp_blocked", 64'(in_ready), 64'd0);
    Selector = 2'd3;
    DEMUX_Data = 32'hB3;
    cycle("bp_other");
    in_valid = 1'b0;
    chk("bp_lane1_kept", 64'(DEMUX_Data1), 64'hB1);

    // Streaming into lane 0 at one word per cycle.
    r0 = recv_lane0;
    out_ready = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      Selector = 2'd0;
      DEMUX_Data = 32'h100 + 32'(k);
      cycle("stream");
    end
    in_valid = 1'b0;
    cycle("stream_tail");
    chk("stream_count", 64'(recv_lane0 - r0), 64'd8);

    // Fill and drain lane 2 in one cycle.
    out_ready = 4'b0000;
    in_valid = 1'b1;
    Selector = 2'd2;
    DEMUX_Data = 32'hA5;
    cycle("fd_fill");
    occ_before = model_count();
    out_ready = 4'b0100;
    DEMUX_Data = 32'h5A;
    cycle("fd_swap");
    in_valid = 1'b0;
    chk("fd_lane2", 64'(DEMUX_Data2), 64'h5A);
    chk("fd_valid2", 64'(out_valid[2]), 64'd1);
`ifdef DEMUX_OCCUPANCY_EN
    chk("fd_occ", 64'(Occupancy), 64'(occ_before));
`endif
    out_ready = 4'b1111;
    cycle("flush");

    // Random soak honouring the producer hold rule.
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = 1'($urandom_range(0, 1));
        Selector = 2'($urandom_range(0, 3));
        DEMUX_Data = $urandom;
      end
      out_ready = 4'($urandom_range(0, 15));
      cycle("soak");
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    cycle("final_drain");
    chk("no_loss", 64'(sent), 64'(recv + dropped + model_count()));
    chk("empty_end", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
